// File: rtl/bus_pkg.sv
// Shared definitions for the core-side bus: arbiter state, master ids,
// LSU access-size encodings and the latched bus request record.
package bus_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic M0 = 1'b0;  // instruction fetch
  localparam logic M1 = 1'b1;  // load/store port

  localparam int NUM_MASTERS = 2;

  // Access size on the hb lines; the arbiter passes these through untouched.
  localparam logic [1:0] HB_WORD = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_BYTE = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  hb;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to
// the master that did not win last time.
module rr_arbiter2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = M0;
    if (req == 2'b11) winner = ~last_grant;
    else if (req[1])  winner = M1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the core data bus between instruction fetch (M0) and load/store
// (M1): round-robin grant, one transfer in flight, timeout abort on hung slaves.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_hb_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_hb_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,

  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [1:0]  bus_hb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_rdata_i,

  output logic        busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_req_t [NUM_MASTERS-1:0] mreq;

  assign mreq[0] = {m0_addr_i, m0_we_i, m0_hb_i, m0_wdata_i};
  assign mreq[1] = {m1_addr_i, m1_we_i, m1_hb_i, m1_wdata_i};

  logic arb_valid;
  logic arb_winner;

  state_e                   state_q,   state_d;
  logic [CNT_W-1:0]         cnt_q,     cnt_d;
  logic                     owner_q,   owner_d;   // also the round-robin history
  bus_req_t                 bus_q,     bus_d;
  logic                     bus_req_q, bus_req_d;
  logic [NUM_MASTERS-1:0]   gnt_q,     gnt_d;
  logic [NUM_MASTERS-1:0]   rvalid_q,  rvalid_d;
  logic [NUM_MASTERS-1:0]   err_q,     err_d;
  logic [31:0]              resp_q,    resp_d;

  rr_arbiter2 u_rr (
    .req        ({m1_req_i, m0_req_i}),
    .last_grant (owner_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    bus_d     = bus_q;
    bus_req_d = bus_req_q;
    resp_d    = resp_q;
    gnt_d     = '0;
    rvalid_d  = '0;
    err_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          bus_d             = mreq[arb_winner];
          owner_d           = arb_winner;
          cnt_d             = '0;
          gnt_d[arb_winner] = 1'b1;
          bus_req_d         = 1'b1;
          state_d           = ACCESS;
        end
      end
      ACCESS: begin
        // Ready beats the timeout when both land in the same cycle.
        if (bus_ready_i) begin
          resp_d            = bus_rdata_i;
          rvalid_d[owner_q] = 1'b1;
          bus_req_d         = 1'b0;
          state_d           = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          resp_d            = '0;
          rvalid_d[owner_q] = 1'b1;
          err_d[owner_q]    = 1'b1;
          bus_req_d         = 1'b0;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any in-flight transfer without a response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= M1;
      bus_q     <= '0;
      bus_req_q <= 1'b0;
      gnt_q     <= '0;
      rvalid_q  <= '0;
      err_q     <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      bus_q     <= bus_d;
      bus_req_q <= bus_req_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
    end
  end

  assign m0_gnt_o    = gnt_q[0];
  assign m1_gnt_o    = gnt_q[1];
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_err_o    = err_q[0];
  assign m1_err_o    = err_q[1];
  assign m0_rdata_o  = resp_q;
  assign m1_rdata_o  = resp_q;

  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = bus_q.addr;
  assign bus_we_o    = bus_q.we;
  assign bus_hb_o    = bus_q.hb;
  assign bus_wdata_o = bus_q.wdata;

  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transfer table, hand-written corner
// sequences, then random traffic against a cycle-level behavioural model.
module tb_bus_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req[2];
  logic [31:0] addr[2];
  logic        we[2];
  logic [1:0]  hb[2];
  logic [31:0] wdata[2];
  logic        gnt[2];
  logic        rvalid[2];
  logic        err[2];
  logic [31:0] rdata[2];
  logic        bus_req, bus_we, ready, busy;
  logic [31:0] bus_addr, bus_wdata, brdata;
  logic [1:0]  bus_hb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(req[0]), .m0_addr_i(addr[0]), .m0_we_i(we[0]), .m0_hb_i(hb[0]),
    .m0_wdata_i(wdata[0]), .m0_gnt_o(gnt[0]), .m0_rvalid_o(rvalid[0]),
    .m0_err_o(err[0]), .m0_rdata_o(rdata[0]),
    .m1_req_i(req[1]), .m1_addr_i(addr[1]), .m1_we_i(we[1]), .m1_hb_i(hb[1]),
    .m1_wdata_i(wdata[1]), .m1_gnt_o(gnt[1]), .m1_rvalid_o(rvalid[1]),
    .m1_err_o(err[1]), .m1_rdata_o(rdata[1]),
    .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_we_o(bus_we),
    .bus_hb_o(bus_hb), .bus_wdata_o(bus_wdata), .bus_ready_i(ready),
    .bus_rdata_i(brdata), .busy_o(busy)
  );

  typedef struct {
    logic        r0, r1;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  hb;
    logic [31:0] wdata;
    int          delay;   // wait cycles before ready; >= TO means never
    logic [31:0] rdata;
    int          win;
    logic        err;
  } vec_t;

  vec_t tbl[11];

  // behavioural model state
  bit          m_busy, m_last, e_err, e_breq;
  int          m_owner, m_acc;
  bit          e_gnt[2], e_rv[2];
  logic [31:0] e_rdata, l_addr, l_wdata;
  logic        l_we;
  logic [1:0]  l_hb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; addr[m] = '0; we[m] = 1'b0; hb[m] = '0; wdata[m] = '0;
    end
    ready  = 1'b0;
    brdata = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_vec(input int i);
    vec_t v = tbl[i];
    int w, done;
    w = v.win;
    req[0] = v.r0;
    req[1] = v.r1;
    for (int m = 0; m < 2; m++) begin
      addr[m]  = (m == w) ? v.addr  : v.addr ^ 32'hFFFF_0000;
      we[m]    = (m == w) ? v.we    : ~v.we;
      hb[m]    = (m == w) ? v.hb    : ~v.hb;
      wdata[m] = (m == w) ? v.wdata : ~v.wdata;
    end
    tick();
    chk($sformatf("v%0d gnt_win", i), gnt[w], 1);
    chk($sformatf("v%0d gnt_other", i), gnt[1-w], 0);
    chk($sformatf("v%0d bus_req", i), bus_req, 1);
    chk($sformatf("v%0d busy", i), busy, 1);
    chk($sformatf("v%0d bus_addr", i), bus_addr, v.addr);
    chk($sformatf("v%0d bus_we", i), bus_we, v.we);
    chk($sformatf("v%0d bus_hb", i), bus_hb, v.hb);
    chk($sformatf("v%0d bus_wdata", i), bus_wdata, v.wdata);
    req[0] = 1'b0;
    req[1] = 1'b0;
    addr[0] = 32'hBAD0_0000;
    addr[1] = 32'hBAD1_0000;
    done = (v.delay < TO) ? v.delay + 1 : TO;
    for (int a = 1; a <= done; a++) begin
      if (a > 1) begin
        chk($sformatf("v%0d hold_req c%0d", i, a), bus_req, 1);
        chk($sformatf("v%0d hold_addr c%0d", i, a), bus_addr, v.addr);
        chk($sformatf("v%0d early_rvalid c%0d", i, a), rvalid[w], 0);
      end
      ready  = (a == v.delay + 1);
      brdata = v.rdata;
      tick();
    end
    ready  = 1'b0;
    brdata = 32'h0BAD_BAD0;
    chk($sformatf("v%0d rvalid", i), rvalid[w], 1);
    chk($sformatf("v%0d rvalid_other", i), rvalid[1-w], 0);
    chk($sformatf("v%0d err", i), err[w], v.err);
    chk($sformatf("v%0d err_other", i), err[1-w], 0);
    chk($sformatf("v%0d rdata", i), rdata[w], v.err ? 32'h0 : v.rdata);
    chk($sformatf("v%0d bus_req_done", i), bus_req, 0);
    chk($sformatf("v%0d busy_done", i), busy, 0);
  endtask

  task automatic model_step;
    int w;
    e_gnt[0] = 0; e_gnt[1] = 0;
    e_rv[0]  = 0; e_rv[1]  = 0;
    e_err    = 0;
    if (!m_busy) begin
      if (req[0] || req[1]) begin
        if (req[0] && req[1]) w = m_last ? 0 : 1;
        else                  w = req[1] ? 1 : 0;
        m_last   = (w == 1);
        m_owner  = w;
        m_busy   = 1;
        m_acc    = 0;
        e_breq   = 1;
        e_gnt[w] = 1;
        l_addr = addr[w]; l_we = we[w]; l_hb = hb[w]; l_wdata = wdata[w];
      end
    end else begin
      m_acc++;
      if (ready) begin
        e_rv[m_owner] = 1; e_rdata = brdata; m_busy = 0; e_breq = 0;
      end else if (m_acc == TO) begin
        e_rv[m_owner] = 1; e_err = 1; e_rdata = '0; m_busy = 0; e_breq = 0;
      end
    end
  endtask

  task automatic model_check(input int c);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rnd%0d gnt%0d", c, m), gnt[m], e_gnt[m]);
      chk($sformatf("rnd%0d rvalid%0d", c, m), rvalid[m], e_rv[m]);
      chk($sformatf("rnd%0d err%0d", c, m), err[m], e_rv[m] & e_err);
      if (e_rv[m]) chk($sformatf("rnd%0d rdata%0d", c, m), rdata[m], e_rdata);
    end
    chk($sformatf("rnd%0d bus_req", c), bus_req, e_breq);
    chk($sformatf("rnd%0d busy", c), busy, m_busy);
    chk($sformatf("rnd%0d bus_addr", c), bus_addr, l_addr);
    chk($sformatf("rnd%0d bus_we", c), bus_we, l_we);
    chk($sformatf("rnd%0d bus_hb", c), bus_hb, l_hb);
    chk($sformatf("rnd%0d bus_wdata", c), bus_wdata, l_wdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    //        r0 r1 addr           we hb     wdata          dly rdata          win err
    tbl[0]  = '{1, 0, 32'h0000_0104, 0, 2'b00, 32'h0,         2,  32'hDEAD_BEEF, 0, 0};
    tbl[1]  = '{1, 0, 32'h0000_0010, 1, 2'b01, 32'h0000_005A, 0,  32'h0000_1234, 0, 0};
    tbl[2]  = '{1, 1, 32'h0000_0020, 0, 2'b10, 32'h0,         1,  32'h2222_0020, 1, 0};
    tbl[3]  = '{1, 1, 32'h0000_0024, 0, 2'b00, 32'h0,         0,  32'h3333_0024, 0, 0};
    tbl[4]  = '{0, 1, 32'h0000_0028, 1, 2'b00, 32'h1111_0028, 0,  32'h4444_0028, 1, 0};
    tbl[5]  = '{0, 1, 32'h0000_002C, 0, 2'b01, 32'h0,         0,  32'h5555_002C, 1, 0};
    tbl[6]  = '{1, 1, 32'h0000_0030, 0, 2'b00, 32'h0,         3,  32'h6666_0030, 0, 0};
    tbl[7]  = '{1, 1, 32'h0000_0034, 1, 2'b10, 32'h7777_0034, 0,  32'h8888_0034, 1, 0};
    tbl[8]  = '{1, 0, 32'h0000_0038, 0, 2'b00, 32'h0,         15, 32'hCAFE_F00D, 0, 0};
    tbl[9]  = '{0, 1, 32'h0000_0200, 1, 2'b00, 32'h0000_0041, 99, 32'h9999_9999, 1, 1};
    tbl[10] = '{1, 1, 32'h0000_0040, 0, 2'b00, 32'h0,         0,  32'hAAAA_0040, 0, 0};

    rst_n = 1'b0;
    idle_inputs();
    tick();
    chk("reset gnt0", gnt[0], 0);
    chk("reset gnt1", gnt[1], 0);
    chk("reset rvalid0", rvalid[0], 0);
    chk("reset bus_req", bus_req, 0);
    chk("reset bus_addr", bus_addr, 0);
    chk("reset busy", busy, 0);
    chk("reset rdata", rdata[0], 0);

    do_reset();
    for (int i = 0; i < 11; i++) run_vec(i);

    // both masters request continuously against a zero-wait slave
    do_reset();
    req[0] = 1; addr[0] = 32'hA0; wdata[0] = 32'hA5;
    req[1] = 1; addr[1] = 32'hB0; wdata[1] = 32'hB5;
    ready = 1; brdata = 32'h77;
    for (int k = 0; k < 4; k++) begin
      int x;
      x = k % 2;
      tick();
      chk($sformatf("rr%0d gnt", k), gnt[x], 1);
      chk($sformatf("rr%0d gnt_other", k), gnt[1-x], 0);
      chk($sformatf("rr%0d bus_addr", k), bus_addr, x ? 32'hB0 : 32'hA0);
      if (k == 3) begin req[0] = 0; req[1] = 0; end
      tick();
      chk($sformatf("rr%0d rvalid", k), rvalid[x], 1);
      chk($sformatf("rr%0d no_gnt", k), gnt[0] | gnt[1], 0);
    end
    ready = 0;
    tick();
    chk("rr idle gnt", gnt[0] | gnt[1], 0);
    chk("rr idle busy", busy, 0);

    // asynchronous reset in the third ACCESS cycle
    do_reset();
    req[0] = 1; addr[0] = 32'h500;
    tick();
    chk("rst gnt", gnt[0], 1);
    req[0] = 0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst async gnt0", gnt[0], 0);
    chk("rst async rvalid0", rvalid[0], 0);
    chk("rst async bus_req", bus_req, 0);
    chk("rst async bus_addr", bus_addr, 0);
    chk("rst async busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1; brdata = 32'h99;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst no_rvalid%0d", k), rvalid[0] | rvalid[1], 0);
      chk($sformatf("rst idle%0d", k), busy, 0);
    end
    ready = 0;
    req[0] = 1; req[1] = 1; addr[0] = 32'h510; addr[1] = 32'h520;
    tick();
    chk("rst tie gnt0", gnt[0], 1);
    chk("rst tie gnt1", gnt[1], 0);
    req[0] = 0; req[1] = 0; ready = 1;
    tick();
    chk("rst tie rvalid", rvalid[0], 1);
    ready = 0;

    // M1 asks while M0 owns the bus
    tick();
    req[0] = 1; addr[0] = 32'h600; we[0] = 0;
    tick();
    chk("pend m0 gnt", gnt[0], 1);
    req[0] = 0;
    tick();
    req[1] = 1; addr[1] = 32'h300; we[1] = 1; hb[1] = 2'b01; wdata[1] = 32'h55;
    tick();
    chk("pend m1 ignored", gnt[1], 0);
    ready = 1; brdata = 32'h1357;
    tick();
    ready = 0;
    chk("pend m0 rvalid", rvalid[0], 1);
    chk("pend m0 rdata", rdata[0], 32'h1357);
    chk("pend m1 not yet", gnt[1], 0);
    tick();
    chk("pend m1 gnt", gnt[1], 1);
    chk("pend m1 addr", bus_addr, 32'h300);
    chk("pend m1 we", bus_we, 1);
    chk("pend m1 wdata", bus_wdata, 32'h55);
    req[1] = 0; ready = 1;
    tick();
    chk("pend m1 rvalid", rvalid[1], 1);
    ready = 0;

    // random traffic against the model
    do_reset();
    m_busy = 0; m_last = 1; m_owner = 0; m_acc = 0;
    e_gnt[0] = 0; e_gnt[1] = 0; e_rv[0] = 0; e_rv[1] = 0;
    e_err = 0; e_breq = 0; e_rdata = '0;
    l_addr = '0; l_we = 0; l_hb = '0; l_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      model_check(c);
      for (int m = 0; m < 2; m++) begin
        if (req[m] && e_gnt[m]) req[m] = 0;
        if (!req[m] && $urandom_range(0, 2) == 0) begin
          req[m] = 1; addr[m] = $urandom; we[m] = 1'($urandom_range(0, 1));
          hb[m] = 2'($urandom_range(0, 3)); wdata[m] = $urandom;
        end
      end
      ready  = ($urandom_range(0, 99) < 20);
      brdata = $urandom;
      model_step();
      tick();
    end

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
